// File: rtl/ring_pkg.sv
// Shared types and constants for the one-hot ring-counter code path.
package ring_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } ring_state_t;

    localparam int RING_WIDTH_DEF = 4;
    localparam int ERR_CNT_W      = 8;

endpackage

// File: rtl/onehot_to_bin.sv
// Combinational one-hot legality flag (popcount == 1) and binary index encoder.
module onehot_to_bin #(
    parameter int WIDTH = 4,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] code,
    output logic             onehot,
    output logic [IDXW-1:0]  idx
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0] ones;

    // idx ORs every set position; it is only meaningful when onehot is high.
    always_comb begin
        ones = '0;
        idx  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (code[i]) begin
                ones = ones + CW'(1);
                idx  = idx | IDXW'(i);
            end
        end
        onehot = (ones == CW'(1));
    end

endmodule

// File: rtl/ring_decoder.sv
// Ring-code receiver: decodes the one-hot code, checks single-step left rotation,
// tracks lock to the sequence and counts error samples.
module ring_decoder
    import ring_pkg::*;
#(
    parameter int WIDTH    = RING_WIDTH_DEF,
    parameter int IDXW     = $clog2(WIDTH),
    parameter int LOCK_CNT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     ring_in,
    output logic [IDXW-1:0]      idx_out,
    output logic                 idx_valid,
    output logic                 onehot_err,
    output logic                 seq_err,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_count
);

    ring_state_t    state, state_d;
    logic [3:0]     good_cnt, good_d;
    logic [IDXW-1:0] prev_idx, prev_d, idx_d, dec_idx, exp_idx;
    logic           have_prev, have_d;
    logic           iv_d, oh_d, seq_d, dec_onehot, match;

    onehot_to_bin #(.WIDTH(WIDTH), .IDXW(IDXW)) u_dec (
        .code   (ring_in),
        .onehot (dec_onehot),
        .idx    (dec_idx)
    );

    // Explicit wrap keeps the check correct for non-power-of-two widths.
    assign exp_idx = (prev_idx == IDXW'(WIDTH - 1)) ? '0 : prev_idx + IDXW'(1);
    assign match   = have_prev && (dec_idx == exp_idx);

    always_comb begin
        state_d = state;
        good_d  = good_cnt;
        prev_d  = prev_idx;
        have_d  = have_prev;
        idx_d   = idx_out;
        iv_d    = 1'b0;
        oh_d    = 1'b0;
        seq_d   = 1'b0;
        if (in_valid) begin
            if (!dec_onehot) begin
                oh_d    = 1'b1;
                state_d = SEARCH;
                have_d  = 1'b0;
                good_d  = '0;
            end else begin
                iv_d   = 1'b1;
                idx_d  = dec_idx;
                prev_d = dec_idx;
                have_d = 1'b1;
                case (state)
                    SEARCH: begin
                        state_d = TRACK;
                        good_d  = '0;
                    end
                    TRACK: begin
                        if (match) begin
                            good_d = good_cnt + 4'd1;
                            if (good_d == 4'(LOCK_CNT)) state_d = LOCKED;
                        end else begin
                            seq_d  = 1'b1;
                            good_d = '0;
                        end
                    end
                    LOCKED: begin
                        if (!match) begin
                            seq_d   = 1'b1;
                            state_d = TRACK;
                            good_d  = '0;
                        end
                    end
                    default: state_d = SEARCH;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= SEARCH;
            good_cnt   <= '0;
            prev_idx   <= '0;
            have_prev  <= 1'b0;
            idx_out    <= '0;
            idx_valid  <= 1'b0;
            onehot_err <= 1'b0;
            seq_err    <= 1'b0;
            locked     <= 1'b0;
            err_count  <= '0;
        end else begin
            state      <= state_d;
            good_cnt   <= good_d;
            prev_idx   <= prev_d;
            have_prev  <= have_d;
            idx_out    <= idx_d;
            idx_valid  <= iv_d;
            onehot_err <= oh_d;
            seq_err    <= seq_d;
            locked     <= (state_d == LOCKED);
            if ((oh_d || seq_d) && (err_count != {ERR_CNT_W{1'b1}}))
                err_count <= err_count + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ring_decoder.sv
// Directed and randomized bench for ring_decoder against a sample-level reference model.
module tb_ring_decoder;

    localparam int W  = 4;
    localparam int LC = 4;

    logic         clk, rst, in_valid;
    logic [W-1:0] ring_in;
    logic [1:0]   idx_out;
    logic         idx_valid, onehot_err, seq_err, locked;
    logic [7:0]   err_count;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_idx, m_prev, m_good, m_err;
    bit m_have, m_locked, m_iv, m_oh, m_seq;

    ring_decoder #(.WIDTH(W), .LOCK_CNT(LC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .ring_in(ring_in),
        .idx_out(idx_out), .idx_valid(idx_valid), .onehot_err(onehot_err),
        .seq_err(seq_err), .locked(locked), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_idx = 0; m_prev = 0; m_good = 0; m_err = 0;
        m_have = 0; m_locked = 0; m_iv = 0; m_oh = 0; m_seq = 0;
    endtask

    // One sample evaluated straight from the behavioural rules.
    task automatic model_sample(input logic v, input logic [W-1:0] code);
        int pos;
        m_iv = 0; m_oh = 0; m_seq = 0;
        if (!v) return;
        if ($countones(code) != 1) begin
            m_oh = 1; m_have = 0; m_good = 0; m_locked = 0;
        end else begin
            pos = 0;
            for (int i = 0; i < W; i++) if (code[i]) pos = i;
            m_iv = 1; m_idx = pos;
            if (m_have) begin
                if (pos == (m_prev + 1) % W) begin
                    if (!m_locked) begin
                        m_good++;
                        if (m_good == LC) m_locked = 1;
                    end
                end else begin
                    m_seq = 1; m_locked = 0; m_good = 0;
                end
            end else begin
                m_good = 0;
            end
            m_prev = pos; m_have = 1;
        end
        if ((m_oh || m_seq) && m_err < 255) m_err++;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".idx_out"},    32'(idx_out),    32'(m_idx));
        chk({tag, ".idx_valid"},  32'(idx_valid),  32'(m_iv));
        chk({tag, ".onehot_err"}, 32'(onehot_err), 32'(m_oh));
        chk({tag, ".seq_err"},    32'(seq_err),    32'(m_seq));
        chk({tag, ".locked"},     32'(locked),     32'(m_locked));
        chk({tag, ".err_count"},  32'(err_count),  32'(m_err));
    endtask

    task automatic step(input string tag, input logic v, input logic [W-1:0] code);
        in_valid = v;
        ring_in  = code;
        @(posedge clk);
        if (!rst) model_reset();
        else      model_sample(v, code);
        #1 check_all(tag);
    endtask

    task automatic rot_code(output logic [W-1:0] code);
        logic [W-1:0] one;
        one = 1;
        code = m_have ? (one << ((m_prev + 1) % W)) : (one << $urandom_range(0, W - 1));
    endtask

    initial begin
        logic [W-1:0] c, one;
        one = 1;
        rst = 1'b0; in_valid = 1'b0; ring_in = '0;
        model_reset();

        // reset held with random inputs
        for (int i = 0; i < 4; i++) step("rst_hold", 1'($urandom), W'($urandom));
        rst = 1'b1;

        // clean run through the wrap
        step("clean0", 1, 4'b0001);
        chk("first_idx_valid", 32'(idx_valid), 32'd1);
        step("clean1", 1, 4'b0010);
        step("clean2", 1, 4'b0100);
        step("clean3", 1, 4'b1000);
        step("clean4", 1, 4'b0001);
        chk("lock_on_5th", 32'(locked), 32'd1);
        step("clean5", 1, 4'b0010);

        // illegal codes while locked, then restart
        step("ill0", 1, 4'b0000);
        step("ill1", 1, 4'b0110);
        chk("ill_err_count", 32'(err_count), 32'd2);
        step("restart", 1, 4'b0100);

        // lock, skip, relock
        step("lk0", 1, 4'b1000);
        step("lk1", 1, 4'b0001);
        step("lk2", 1, 4'b0010);
        step("lk3", 1, 4'b0100);
        step("lk4", 1, 4'b1000);
        step("lk5", 1, 4'b0001);
        step("lk6", 1, 4'b0010);
        step("skip", 1, 4'b1000);
        chk("skip_seq_err", 32'(seq_err), 32'd1);
        step("rl0", 1, 4'b0001);
        step("rl1", 1, 4'b0010);
        step("rl2", 1, 4'b0100);
        step("rl3", 1, 4'b1000);
        chk("relock", 32'(locked), 32'd1);

        // bubbles between samples
        for (int i = 0; i < 6; i++) begin
            rot_code(c);
            step("gap_s", 1, c);
            step("gap_b", 0, W'($urandom));
        end

        // asynchronous reset mid-run
        #3 rst = 1'b0;
        #1 model_reset();
        check_all("async_rst");
        step("rst_mid", 1, 4'b0100);
        rst = 1'b1;
        step("post_rst0", 1, 4'b0100);
        step("post_rst1", 1, 4'b1000);

        // randomized mix
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: rot_code(c);
                6: c = W'($urandom);
                7: c = one << $urandom_range(0, W - 1);
                8: c = m_have ? (one << m_prev) : 4'b0011;
                default: c = 4'b1111;
            endcase
            step("rand", ($urandom_range(0, 4) != 0), c);
        end

        // saturation
        #3 rst = 1'b0;
        #1 model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 300; i++) step("sat", 1, 4'b0001);
        chk("sat_255", 32'(err_count), 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
